// File: rtl/matvec_pkg.sv
// Shared constants and types for the sequential 3x4 matrix-vector MAC controller.
// The MATVEC_ROW_OUT_EN macro selects per-row result words instead of one total.
package matvec_pkg;

   localparam int DEF_ROWS = 3;
   localparam int DEF_COLS = 4;
   localparam int DEF_DW   = 32;

   // Counter width helper that never returns zero, so one-entry ranges still get a bit.
   function automatic int cw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int NWORDS = DEF_ROWS * DEF_COLS + DEF_COLS;
   localparam int WCNT_W = cw(NWORDS + 1);
   localparam int MCNT_W = cw(DEF_ROWS * DEF_COLS);

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      OUT
   } state_t;

endpackage

// File: rtl/matvec_mac.sv
// Registered multiply-accumulate with wrapping arithmetic. Clear together with enable
// restarts the sum at the current product instead of zero.
module matvec_mac
   import matvec_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] acc_o
);

   logic [DW-1:0] acc_q;
   logic [DW-1:0] acc_d;
   logic [DW-1:0] prod;

   // Only the low DW bits of the product matter; the sum wraps modulo 2^DW.
   assign prod = a_i * b_i;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = en_i ? prod : '0;
      end else if (en_i) begin
         acc_d = acc_q + prod;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/matvec_seq_ctrl.sv
// Loads a ROWSxCOLS matrix and COLS vector over a stream, then sums all products on one MAC.
// Defining MATVEC_ROW_OUT_EN returns one word per row sum instead of a single total.
module matvec_seq_ctrl
   import matvec_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   parameter int DW   = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy
);

   localparam int NM  = ROWS * COLS;
   localparam int NW  = NM + COLS;
   localparam int WCW = cw(NW + 1);
   localparam int KW  = cw(NM);
   localparam int JW  = cw(COLS);
   localparam int IW  = cw(ROWS);

   state_t         state_q, state_d;
   logic           rdy_q;
   logic [WCW-1:0] wcnt_q;
   logic [KW-1:0]  k_q;
   logic [JW-1:0]  j_q;
   logic [IW-1:0]  i_q;
   logic [DW-1:0]  m_q [NM];
   logic [DW-1:0]  v_q [COLS];
   logic [NM-1:0]  m_we;
   logic [COLS-1:0] v_we;

   logic           xfer, last_word, last_mac, out_hs, job_done;
   logic           mac_clr, mac_en;
   logic [DW-1:0]  mac_acc;

   // in_ready stays low until the first clock after reset release.
   assign in_ready  = (state_q == IDLE) && rdy_q;
   assign xfer      = in_valid && in_ready;
   assign last_word = xfer && (wcnt_q == WCW'(NW - 1));
   assign last_mac  = (state_q == COMPUTE) && (k_q == KW'(NM - 1));
   assign out_hs    = (state_q == OUT) && out_ready;
   assign out_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);

   generate
      for (genvar gi = 0; gi < NM; gi++) begin : g_m_we
         assign m_we[gi] = xfer && (wcnt_q == WCW'(gi));
      end
      for (genvar gi = 0; gi < COLS; gi++) begin : g_v_we
         assign v_we[gi] = xfer && (wcnt_q == WCW'(NM + gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NM; n++) m_q[n] <= '0;
         for (int n = 0; n < COLS; n++) v_q[n] <= '0;
      end else begin
         for (int n = 0; n < NM; n++) if (m_we[n]) m_q[n] <= in_data;
         for (int n = 0; n < COLS; n++) if (v_we[n]) v_q[n] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         if (job_done) begin
            wcnt_q <= '0;
         end else if (xfer) begin
            wcnt_q <= wcnt_q + WCW'(1);
         end
      end
   end

   // k walks the matrix row-major; j/i track the vector index and row alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q <= '0;
         j_q <= '0;
         i_q <= '0;
      end else if (state_q == COMPUTE) begin
         if (last_mac) begin
            k_q <= '0;
            j_q <= '0;
            i_q <= '0;
         end else begin
            k_q <= k_q + KW'(1);
            if (j_q == JW'(COLS - 1)) begin
               j_q <= '0;
               i_q <= i_q + IW'(1);
            end else begin
               j_q <= j_q + JW'(1);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (last_word) begin
               state_d = COMPUTE;
               mac_clr = 1'b1;
            end
         end
         COMPUTE: begin
            mac_en = 1'b1;
`ifdef MATVEC_ROW_OUT_EN
            mac_clr = (j_q == '0);
`endif
            if (last_mac) state_d = OUT;
         end
         OUT: begin
            if (job_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   matvec_mac #(.DW(DW)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (mac_clr),
      .en_i  (mac_en),
      .a_i   (m_q[k_q]),
      .b_i   (v_q[j_q]),
      .acc_o (mac_acc)
   );

`ifdef MATVEC_ROW_OUT_EN
   logic [IW-1:0] oidx_q;
   logic [DW-1:0] row_sum_q [ROWS];
   logic [ROWS-1:0] rs_cap;
   logic [DW-1:0] row_word;

   // The MAC restarts at each row, so at the first column of row i it holds row i-1's sum.
   // The final row is read straight from the accumulator, which is idle during OUT.
   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_rs_cap
         assign rs_cap[gi] = (state_q == COMPUTE) && (j_q == '0) && (int'(i_q) == gi + 1);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < ROWS; n++) row_sum_q[n] <= '0;
         oidx_q <= '0;
      end else begin
         for (int n = 0; n < ROWS; n++) if (rs_cap[n]) row_sum_q[n] <= mac_acc;
         if (job_done) begin
            oidx_q <= '0;
         end else if (out_hs) begin
            oidx_q <= oidx_q + IW'(1);
         end
      end
   end

   assign job_done = out_hs && (oidx_q == IW'(ROWS - 1));
   assign row_word = (oidx_q == IW'(ROWS - 1)) ? mac_acc : row_sum_q[oidx_q];
   assign out_data = (state_q == OUT) ? row_word : '0;
   assign out_last = (state_q == OUT) && (oidx_q == IW'(ROWS - 1));
`else
   assign job_done = out_hs;
   assign out_data = (state_q == OUT) ? mac_acc : '0;
   assign out_last = (state_q == OUT);
`endif

endmodule

// File: doc/matvec_seq_ctrl.md
Name: matvec_seq_ctrl

Overview:
Sequencing controller for the 3x4 matrix-vector multiply-accumulate function. It accepts operands over a valid/ready stream into local registers, then computes on one shared 32-bit MAC, one product per cycle. It returns the scalar sum of all matrix[i][j]*vector[j] products over a valid/ready output. It replaces the fully parallel combinational array wherever area matters more than latency.

Parameters:
ROWS, 3, matrix row count
COLS, 4, matrix column count and vector length
DW, 32, data width of operands, accumulator and result

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand word valid
in_ready  out  1  controller can accept an operand word
in_data  in  DW  operand word
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts result
out_data  out  DW  result word
out_last  out  1  final result word of this job
busy  out  1  high in COMPUTE or OUT

Behaviour:
- Clocking and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=0 during reset and 1 from the first clock after release, out_valid=0, out_data=0, out_last=0, busy=0. All counters, the accumulator and the operand registers are cleared.
- Operand load order: exactly ROWS*COLS+COLS words (16) per job.
  - Matrix first, row-major: m[0][0], m[0][1] … m[2][3].
  - Then vector: v[0] … v[3].
- Word transfer: a word transfers on any clk edge where in_valid && in_ready. The word counter increments per transfer.
- States:
  - IDLE: in_ready=1. On acceptance of the 16th word, go to COMPUTE and clear the accumulator.
  - COMPUTE: in_ready=0, busy=1.
    - Each cycle: acc <= acc + m[i][j]*v[j]. Index j is inner, i is outer.
    - Runs exactly ROWS*COLS cycles (12), then goes to OUT.
  - OUT: out_valid=1 and busy=1. out_data and out_last are held stable while out_ready=0.
    - On out_valid && out_ready: go to IDLE, clear the word counter, out_valid=0 next cycle.
- Latency: last input accepted at edge T; out_valid rises after edge T+12. In-to-out latency is 12 cycles, plus 1 cycle minimum before the next job's in_ready.
- Arithmetic: product is the low DW bits of the DW x DW unsigned multiply. The accumulator wraps modulo 2^DW, with no saturation and no flag.
- Boundaries:
  - in_valid asserted in COMPUTE or OUT is ignored; no word is consumed.
  - in_valid low mid-load: the controller waits indefinitely with the partial count retained.
  - out_ready held high entering OUT: handshake completes in the first OUT cycle.
  - rst_n asserted mid-load, mid-compute or mid-OUT: immediate return to IDLE with all state cleared; the partial job is discarded.

Optional Feature:
MATVEC_ROW_OUT_EN
- Defined:
  - OUT emits ROWS words in sequence: row_sum[0], row_sum[1], row_sum[2]. Each row_sum[i] = sum over j of m[i][j]*v[j], wrapped to DW bits.
  - out_last=1 only on row_sum[ROWS-1]. Each word needs its own handshake.
  - Return to IDLE follows the last handshake.
  - Row sums are captured at each row boundary during COMPUTE.
- Undefined: a single total-sum word is emitted with out_last=1, and no row-sum registers exist.

Decomposition:
- Package matvec_pkg contains:
  - ROWS, COLS, DW defaults.
  - Derived constants NWORDS=ROWS*COLS+COLS, word-counter width, MAC-counter width.
  - State enum typedef {IDLE, COMPUTE, OUT}.
- Sub-module matvec_mac: registered DW-bit multiply-accumulate with synchronous clear and enable, wrapping arithmetic. The controller instantiates one.

Test Plan:
- Matrix all 1, vector [1,2,3,4] -> out_data=30 (0x1E), out_last=1, out_valid exactly 12 cycles after the 16th accepted word. With MATVEC_ROW_OUT_EN: 10, 10, 10, with out_last on the third word.
- Wrap: m[0][0]=0xFFFFFFFF, v[0]=2, all others 0 -> out_data=0xFFFFFFFE.
- Backpressure: out_ready low for 20 cycles in OUT -> out_data stable and in_ready=0 throughout. Raise out_ready -> one handshake, then in_ready=1 next cycle.
- Gapped input: in_valid toggled every other cycle, plus in_valid held high during COMPUTE -> exactly 16 words consumed, correct sum, extra words not consumed.
- Reset mid-COMPUTE (cycle 5), then a new job with m=identity-like 1s on m[i][i], v=[5,6,7,8] -> no stale output; out_data=18.
- Back-to-back jobs with out_ready tied 1 -> second result independent of the first (accumulator cleared).
